// File: rtl/program_loader_pkg.sv
// Shared cpu package: loader FSM state encoding and program-length ceiling.
package program_loader_pkg;

  localparam int PROG_LEN_MAX = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SETUP,
    STROBE,
    HOLD,
    CHECK,
    FINISH
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams PROG_LEN bytes into the CPU RAM via its manual-programming port, holding the CPU in reset meanwhile.
// Optional trailing checksum byte verification is enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int PROG_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] mar_address,
  output logic [7:0] ram_data,
  output logic       ram_mode,
  output logic       ram_pulse,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [3:0] LAST_ADDR = 4'(PROG_LEN - 1);

  loader_state_t state, state_nxt;
  logic [3:0]    addr;
  logic [7:0]    data_q;
  logic          accept_byte;

  assign accept_byte = (state == WAIT_BYTE) && in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= 4'd0;
      data_q <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        addr <= 4'd0;
      end else if (state == HOLD && addr != LAST_ADDR) begin
        addr <= addr + 4'd1;
      end
      if (accept_byte) begin
        data_q <= in_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       error_q;
  logic       sum_ok;

  assign sum_ok = (in_data == sum);

  // The checksum byte itself is compared, never accumulated nor latched into ram_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum     <= 8'd0;
      error_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sum     <= 8'd0;
        error_q <= 1'b0;
      end else if (accept_byte) begin
        sum <= sum + in_data;
      end
      if (state == CHECK && in_valid && !sum_ok) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ram_pulse = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SETUP;
      end
      SETUP: state_nxt = STROBE;
      STROBE: begin
        ram_pulse = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (addr == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = FINISH;
`endif
        end else begin
          state_nxt = WAIT_BYTE;
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (in_valid) state_nxt = sum_ok ? FINISH : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign ram_mode    = busy;
  // A failed checksum keeps the CPU parked in reset while the loader idles.
  assign cpu_hold    = busy | error;
  assign mar_address = addr;
  assign ram_data    = data_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, stalled byte, ignored restart, mid-session reset,
// and (with LOADER_CHECKSUM_EN) checksum match/mismatch on a PROG_LEN=2 instance.
module tb_program_loader;

  localparam int PL = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK_EXTRA = 1;
`else
  localparam int CK_EXTRA = 0;
`endif
  localparam logic [7:0] CK_BYTE = 8'h78;  // sum of 0x00..0x0F

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] mar_address;
  logic [7:0] ram_data;
  logic       ram_mode, ram_pulse, cpu_hold, busy, done, error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  program_loader #(.PROG_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mar_address(mar_address), .ram_data(ram_data),
    .ram_mode(ram_mode), .ram_pulse(ram_pulse),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe log and write-strobe hygiene monitor.
  int         n_strobe = 0;
  logic [3:0] s_addr [0:31];
  logic [7:0] s_data [0:31];
  logic       prev_pulse = 1'b0;
  logic [3:0] prev_addr = 4'd0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    if (ram_pulse === 1'b1) begin
      chk("pulse_single", {31'd0, prev_pulse}, 32'd0);
      chk("pulse_addr_stable", {28'd0, mar_address}, {28'd0, prev_addr});
      chk("pulse_data_stable", {24'd0, ram_data}, {24'd0, prev_data});
      if (n_strobe < 32) begin
        s_addr[n_strobe] = mar_address;
        s_data[n_strobe] = ram_data;
      end
      n_strobe++;
    end
    prev_pulse = ram_pulse;
    prev_addr  = mar_address;
    prev_data  = ram_data;
  end

  bit done_seen;
  int sess_lat;

  task automatic run_session(input int hold_idx, input int hold_len, input int restart_addr, input int rst_addr);
    int idx = 0;
    int held = 0;
    int first = -1;
    bit restarted = 0;
    bit fin = 0;
    done_seen = 0;
    sess_lat = -1;
    n_strobe = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (done === 1'b1) begin
        fin = 1;
        done_seen = 1;
        sess_lat = cyc - first;
      end else if (rst_addr >= 0 && ram_pulse === 1'b1 && mar_address == rst_addr[3:0]) begin
        rst_n = 1'b0;
        fin = 1;
      end else begin
        start = 1'b0;
        if (restart_addr >= 0 && !restarted && busy && mar_address == restart_addr[3:0]) begin
          start = 1'b1;
          restarted = 1;
        end
        in_data = (idx < PL) ? 8'(idx) : CK_BYTE;
        if (idx == hold_idx && held < hold_len && in_ready === 1'b1) begin
          in_valid = 1'b0;
          held++;
          chk("withhold_ready", {31'd0, in_ready}, 32'd1);
          chk("withhold_no_strobe", n_strobe, hold_idx);
        end else begin
          in_valid = 1'b1;
        end
        if (in_ready === 1'b1 && in_valid) begin
          if (first < 0) first = cyc;
          idx++;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_complete(input string tag);
    chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    @(negedge clk);
    chk({tag, "_cpu_hold_released"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_ram_mode_off"}, {31'd0, ram_mode}, 32'd0);
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_strobe_count"}, n_strobe, PL);
    for (int i = 0; i < PL; i++) begin
      chk({tag, "_strobe_addr"}, {28'd0, s_addr[i]}, i);
      chk({tag, "_strobe_data"}, {24'd0, s_data[i]}, i);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mar_address"}, {28'd0, mar_address}, 32'd0);
    chk({tag, "_ram_data"}, {24'd0, ram_data}, 32'd0);
    chk({tag, "_ram_mode"}, {31'd0, ram_mode}, 32'd0);
    chk({tag, "_ram_pulse"}, {31'd0, ram_pulse}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  logic       ck_start = 1'b0;
  logic [7:0] ck_in_data = 8'd0;
  logic       ck_in_valid = 1'b0;
  logic       ck_in_ready;
  logic [3:0] ck_mar_address;
  logic [7:0] ck_ram_data;
  logic       ck_ram_mode, ck_ram_pulse, ck_cpu_hold, ck_busy, ck_done, ck_error;

  program_loader #(.PROG_LEN(2)) dut_ck (
    .clk(clk), .rst_n(rst_n), .start(ck_start),
    .in_data(ck_in_data), .in_valid(ck_in_valid), .in_ready(ck_in_ready),
    .mar_address(ck_mar_address), .ram_data(ck_ram_data),
    .ram_mode(ck_ram_mode), .ram_pulse(ck_ram_pulse),
    .cpu_hold(ck_cpu_hold), .busy(ck_busy), .done(ck_done), .error(ck_error)
  );

  task automatic ck_send(input logic [7:0] b);
    int n = 0;
    while (ck_in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ck_ready_timeout", {31'd0, ck_in_ready}, 32'd1);
    ck_in_valid = 1'b1;
    ck_in_data = b;
    @(negedge clk);
    ck_in_valid = 1'b0;
  endtask

  task automatic ck_session(input logic [7:0] cks);
    @(negedge clk);
    ck_start = 1'b1;
    @(negedge clk);
    ck_start = 1'b0;
    ck_send(8'h10);
    ck_send(8'h20);
    ck_send(cks);
  endtask
`endif

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Plain load: 0x00..0x0F, in_valid always high.
    run_session(-1, 0, -1, -1);
    chk("plain_done_latency", sess_lat, 64 + CK_EXTRA);
    check_complete("plain");

    // Byte 3 withheld for 10 cycles.
    run_session(3, 10, -1, -1);
    chk("stall_done_latency", sess_lat, 74 + CK_EXTRA);
    check_complete("stall");

    // start re-pulsed at address 7 must be ignored.
    run_session(-1, 0, 7, -1);
    chk("restart_done_latency", sess_lat, 64 + CK_EXTRA);
    check_complete("restart");

    // Reset during the strobe of address 5.
    run_session(-1, 0, -1, 5);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h66;
    repeat (12) @(negedge clk);
    in_valid = 1'b0;
    chk("midreset_strobe_count", n_strobe, 6);
    chk("midreset_last_addr", {28'd0, s_addr[5]}, 32'd5);
    chk("midreset_stays_idle", {31'd0, busy}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    ck_session(8'h30);
    chk("ck_match_done", {31'd0, ck_done}, 32'd1);
    chk("ck_match_error", {31'd0, ck_error}, 32'd0);
    @(negedge clk);
    chk("ck_match_hold_released", {31'd0, ck_cpu_hold}, 32'd0);

    ck_session(8'h31);
    chk("ck_mismatch_done", {31'd0, ck_done}, 32'd0);
    chk("ck_mismatch_error", {31'd0, ck_error}, 32'd1);
    chk("ck_mismatch_cpu_hold", {31'd0, ck_cpu_hold}, 32'd1);
    chk("ck_mismatch_idle", {31'd0, ck_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ck_mismatch_no_late_done", {31'd0, ck_done}, 32'd0);
    chk("ck_mismatch_hold_kept", {31'd0, ck_cpu_hold}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter PROG_LEN, default 16, number of bytes loaded per session (legal 1..16).
REQ-002 SHALL have port clk  input  1  single CPU-domain clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request a load session.
REQ-005 SHALL have ports in_data  input  8  program byte; in_valid  input  1  byte offered; in_ready  output  1  loader accepts byte.
REQ-006 SHALL have ports mar_address  output  4 and ram_data  output  8, driving the RAM manual-programming address and data inputs.
REQ-007 SHALL have ports ram_mode  output  1  (manual programming select) and ram_pulse  output  1  (manual write strobe).
REQ-008 SHALL have ports cpu_hold  output  1  (holds CPU in reset), busy  output  1, done  output  1 (one-cycle pulse) and error  output  1.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT_BYTE, SETUP, STROBE, HOLD, CHECK, FINISH.
REQ-010 IDLE: start=1 -> WAIT_BYTE, address counter cleared to 0, error cleared; start is ignored in every other state.
REQ-011 in_ready SHALL be 1 only in WAIT_BYTE; a byte is accepted on a cycle with in_valid=1 and in_ready=1, latched into ram_data, FSM -> SETUP.
REQ-012 SETUP (1 cycle): mar_address and ram_data stable, ram_pulse=0; -> STROBE.
REQ-013 STROBE (1 cycle): ram_pulse=1, address/data unchanged; -> HOLD.
REQ-014 HOLD (1 cycle): ram_pulse=0, address/data unchanged; if address=PROG_LEN-1 -> CHECK (or FINISH when checksum disabled), else increment address and -> WAIT_BYTE.
REQ-015 Per-byte cost SHALL be 4 cycles minimum (accept, SETUP, STROBE, HOLD); in_valid stall lengthens only WAIT_BYTE.
REQ-016 Address counter SHALL never wrap: the PROG_LEN-1 limit ends the byte phase; PROG_LEN=16 ends at address 15.
REQ-017 ram_mode and cpu_hold SHALL be 1 from leaving IDLE until leaving FINISH; busy=1 in every non-IDLE state.
REQ-018 FINISH (1 cycle): done=1, then -> IDLE with ram_mode=0 and cpu_hold=0 on the next cycle.
REQ-019 ram_pulse SHALL never be high for more than one consecutive cycle and never while address or data is changing.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force IDLE, address=0, ram_data=0, mar_address=0, ram_mode=0, ram_pulse=0, cpu_hold=0, busy=0, done=0, error=0, in_ready=0.
REQ-021 Reset mid-session SHALL abort without further RAM strobes; bytes already written stay in RAM.

Configuration
REQ-022 With LOADER_CHECKSUM_EN defined, the loader SHALL keep an 8-bit mod-256 running sum of accepted program bytes; CHECK waits for one extra byte via the same handshake and compares it with the sum, and the checksum byte is never written to RAM.
REQ-023 With LOADER_CHECKSUM_EN defined, a match SHALL go to FINISH; a mismatch SHALL set error=1 and go to IDLE with cpu_hold held at 1 and done not pulsed, until the next start or reset.
REQ-024 Without LOADER_CHECKSUM_EN, CHECK and the sum register SHALL be absent and error SHALL be tied 0.

Structure
REQ-025 The loader state enum and PROG_LEN maximum (16) SHALL live in the shared cpu package.
REQ-026 Sub-module: none required; the optional checksum accumulator SHALL be inline.

Verification
REQ-027 PROG_LEN=16, start, 16 bytes 0x00..0x0F with in_valid always 1 -> 16 strobes at addresses 0..15 with data = address, done pulse 64 cycles after first accept, cpu_hold released next cycle.
REQ-028 Byte 3 withheld 10 cycles -> in_ready stays 1 and no strobe until it arrives; no address skip.
REQ-029 start pulsed again mid-session at address 7 -> ignored, session completes normally.
REQ-030 rst_n low for 1 cycle during STROBE of address 5 -> all outputs at reset values next cycle, no strobe at address 6.
REQ-031 LOADER_CHECKSUM_EN, PROG_LEN=2, bytes 0x10,0x20, checksum 0x30 -> done=1, error=0; checksum 0x31 -> error=1, cpu_hold=1, no done.
